// File: rtl/backend_command_responder.sv
`default_nettype none
// ============================================================================
//  Module      : backend_command_responder
//  Description : Stand-in backend for the Global Controller. Accepts read and
//                write commands, keeps writes in a small local memory and
//                returns read data in order after a fixed latency through a
//                bounded outstanding-read queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module backend_command_responder #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 128,
    parameter int MEM_AW   = 4,
    parameter int READ_LAT = 4,
    parameter int QDEPTH   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_backend_controller_ready,
    input  logic              i_frontend_command_valid,
    input  logic [ADDR_W:0]   i_frontend_command,
    input  logic [DATA_W-1:0] i_frontend_write_data,
    input  logic              i_stall_backend_controller,
    input  logic              i_frontend_receive_ready,
    output logic              o_returned_data_valid,
    output logic [DATA_W-1:0] o_returned_data
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_ptr_w     = $clog2(QDEPTH);
    localparam int c_cnt_w     = c_ptr_w + 1;
    localparam int c_mem_depth = 1 << MEM_AW;

    localparam logic [c_cnt_w-1:0] c_qdepth     = c_cnt_w'(QDEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);
    // Timer is loaded one short of the latency: the load edge itself counts
    // as the first cycle of the wait.
    localparam logic [3:0]         c_timer_init = 4'(READ_LAT - 1);

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem     [c_mem_depth];
    logic [DATA_W-1:0]  r_q_data  [QDEPTH];
    logic [3:0]         r_q_timer [QDEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // ------------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------------
    logic              w_cmd_is_write;
    logic [MEM_AW-1:0] w_cmd_idx;
    logic              w_accept;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic [DATA_W-1:0] w_rd_data;

    assign w_cmd_is_write = i_frontend_command[ADDR_W];
    assign w_cmd_idx      = i_frontend_command[MEM_AW-1:0];

    // Address bits above the memory index alias silently onto the same entry.
    generate
        if (ADDR_W > MEM_AW) begin : g_addr_alias
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^i_frontend_command[ADDR_W-1:MEM_AW];
        end
    endgenerate

    // Ready has no bypass from a same-cycle pop: only the registered
    // occupancy decides whether there is room.
    assign o_backend_controller_ready = i_rst_n
                                      & ~i_stall_backend_controller
                                      & (r_count < c_qdepth);

    assign w_accept    = i_frontend_command_valid & o_backend_controller_ready;
    assign w_wr_accept = w_accept &  w_cmd_is_write;
    assign w_rd_accept = w_accept & ~w_cmd_is_write;

    // Read data is captured at accept time; only one command is taken per
    // cycle so a read never races a write in the same cycle.
    assign w_rd_data   = r_mem[w_cmd_idx];

    // ------------------------------------------------------------------------
    // Queue head and return path
    // ------------------------------------------------------------------------
    logic              w_q_empty;
    logic [3:0]        w_head_timer;
    logic              w_pop;

    assign w_q_empty    = (r_count == '0);
    assign w_head_timer = r_q_timer[r_rd_ptr];

    // Valid is held until the controller takes the beat; head data cannot
    // change while the head entry stays in place, so data is stable too.
    assign o_returned_data_valid = ~w_q_empty & (w_head_timer == 4'd0);
    assign o_returned_data       = w_q_empty ? '0 : r_q_data[r_rd_ptr];
    assign w_pop                 = o_returned_data_valid & i_frontend_receive_ready;

    // ------------------------------------------------------------------------
    // Local memory: written on write accept, cleared by reset
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_mem_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_accept) begin
            r_mem[w_cmd_idx] <= i_frontend_write_data;
        end
    end

    // ------------------------------------------------------------------------
    // Queue entries: all timers count down to zero, a push reloads its slot
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_data[i]  <= '0;
                r_q_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (r_q_timer[i] != 4'd0) begin
                    r_q_timer[i] <= r_q_timer[i] - 4'd1;
                end
            end
            // Later assignment overrides the decrement for the tail slot.
            if (w_rd_accept) begin
                r_q_data[r_wr_ptr]  <= w_rd_data;
                r_q_timer[r_wr_ptr] <= c_timer_init;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Queue pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_rd_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_rd_accept, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
